// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: add, sub, shift-add multiply and (with ALU_DIV_EN)
// restoring divide, behind an Init/Busy/Done handshake. Define ALU_DIV_EN to build the divider.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         Select,
    input  logic               Init,
    output logic [2*WIDTH-1:0] Sal,
    output logic               Cout,
    output logic               Done,
    output logic               Busy,
    output logic               DivZ
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         sel_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] sal_q, sal_d;
    logic               cout_q, cout_d;
    logic               divz_q, divz_d;
    logic               done_q, busy_q;

    logic [WIDTH:0]     add_w, sub_w, mul_sum;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
`endif

    // p_q holds {acc, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        add_w   = {1'b0, a_q} + {1'b0, b_q};
        sub_w   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        p_d     = {mul_sum, p_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
        div_ge   = rem_sh >= {1'b0, b_q};
        div_diff = rem_sh[WIDTH-1:0] - b_q;
        if (sel_q[0])
            p_d = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge};
`endif
    end

    always_comb begin
        sal_d  = '0;
        cout_d = 1'b0;
        divz_d = 1'b0;
        case (sel_q)
            2'b00: begin
                sal_d  = {{WIDTH{1'b0}}, add_w[WIDTH-1:0]};
                cout_d = add_w[WIDTH];
            end
            2'b01: begin
                sal_d  = {{WIDTH{1'b0}}, sub_w[WIDTH-1:0]};
                cout_d = sub_w[WIDTH];
            end
            2'b10: sal_d = p_q;
            default: begin
`ifdef ALU_DIV_EN
                sal_d  = p_q;
                divz_d = (b_q == '0);
`endif
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            sal_q   <= '0;
            cout_q  <= 1'b0;
            divz_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (Init) begin
                    a_q    <= A;
                    b_q    <= B;
                    sel_q  <= Select;
                    divz_q <= 1'b0;
                    busy_q <= 1'b1;
                    p_q    <= {{WIDTH{1'b0}}, A};
                    cnt_q  <= CW'(WIDTH);
`ifdef ALU_DIV_EN
                    state_q <= Select[1] ? CALC : FIN;
`else
                    state_q <= (Select == 2'b10) ? CALC : FIN;
`endif
                end
                CALC: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIN;
                end
                FIN: begin
                    sal_q   <= sal_d;
                    cout_q  <= cout_d;
                    divz_q  <= divz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Sal  = sal_q;
    assign Cout = cout_q;
    assign DivZ = divz_q;
    assign Done = done_q;
    assign Busy = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: WIDTH=4 instance for the op mix, WIDTH=8 instance for wide multiply.
module tb_alu_seq;
    logic       Clk = 1'b0, Rst_n = 1'b0;
    logic [3:0] A = '0, B = '0;
    logic [1:0] Select = '0;
    logic       Init = 1'b0;
    logic [7:0] Sal;
    logic       Cout, Done, Busy, DivZ;

    logic [7:0]  A8 = '0, B8 = '0;
    logic [1:0]  Select8 = 2'b10;
    logic        Init8 = 1'b0;
    logic [15:0] Sal8;
    logic        Cout8, Done8, Busy8, DivZ8;

    int checks = 0, failures = 0;

    typedef struct {
        logic [7:0] sal;
        logic       cout;
        logic       divz;
        int         lat;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    alu_seq #(.WIDTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Select(Select), .Init(Init),
        .Sal(Sal), .Cout(Cout), .Done(Done), .Busy(Busy), .DivZ(DivZ)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Rst_n(Rst_n), .A(A8), .B(B8), .Select(Select8), .Init(Init8),
        .Sal(Sal8), .Cout(Cout8), .Done(Done8), .Busy(Busy8), .DivZ(DivZ8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   s;
        e.sal = 8'h00; e.cout = 1'b0; e.divz = 1'b0; e.lat = 1;
        case (sel)
            2'b00: begin s = int'(a) + int'(b); e.sal = 8'(s % 16); e.cout = (s > 15); end
            2'b01: begin s = int'(a) - int'(b) + 16; e.sal = 8'(s % 16); e.cout = (a >= b); end
            2'b10: begin e.sal = 8'(int'(a) * int'(b)); e.lat = 5; end
            default: begin
`ifdef ALU_DIV_EN
                e.lat = 5;
                if (b == 4'd0) begin e.sal = {a, 4'hF}; e.divz = 1'b1; end
                else e.sal = 8'((int'(a) % int'(b)) * 16 + int'(a) / int'(b));
`endif
            end
        endcase
        return e;
    endfunction

    // poke: a rival Init with new operands while busy; b2b: start in the Done cycle.
    task automatic run_op(input string tag, input logic [1:0] sel, input logic [3:0] a,
                          input logic [3:0] b, input bit poke, input bit b2b);
        exp_t e;
        int   lat;
        if (!b2b) @(negedge Clk);
        Select = sel; A = a; B = b; Init = 1'b1;
        sb.push_back(model(sel, a, b));
        @(negedge Clk);
        Init = 1'b0;
        check({tag, ":busy"}, 32'(Busy), 32'd1);
        check({tag, ":done_low"}, 32'(Done), 32'd0);
        lat = 0;
        while (Done !== 1'b1 && lat < 40) begin
            @(negedge Clk);
            lat++;
            if (poke && lat == 1) begin Init = 1'b1; Select = 2'b00; A = ~a; B = ~b; end
            else Init = 1'b0;
        end
        e = sb.pop_front();
        check({tag, ":latency"}, 32'(lat), 32'(e.lat));
        check({tag, ":sal"}, 32'(Sal), 32'(e.sal));
        check({tag, ":cout"}, 32'(Cout), 32'(e.cout));
        check({tag, ":divz"}, 32'(DivZ), 32'(e.divz));
        check({tag, ":busy_end"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        repeat (3) @(negedge Clk);
        check("rst:sal", 32'(Sal), 32'd0);
        check("rst:cout", 32'(Cout), 32'd0);
        check("rst:done", 32'(Done), 32'd0);
        check("rst:busy", 32'(Busy), 32'd0);
        check("rst:divz", 32'(DivZ), 32'd0);
        check("rst:sal8", 32'(Sal8), 32'd0);
        Rst_n = 1'b1;

        run_op("add_9_8", 2'b00, 4'd9, 4'd8, 1'b0, 1'b0);
        run_op("add_f_f", 2'b00, 4'hF, 4'hF, 1'b0, 1'b0);
        run_op("sub_3_5", 2'b01, 4'd3, 4'd5, 1'b0, 1'b0);
        run_op("sub_5_3", 2'b01, 4'd5, 4'd3, 1'b0, 1'b1);
        run_op("sub_7_7", 2'b01, 4'd7, 4'd7, 1'b0, 1'b0);
        run_op("mul_f_f", 2'b10, 4'hF, 4'hF, 1'b1, 1'b0);
        run_op("mul_0_9", 2'b10, 4'd0, 4'd9, 1'b0, 1'b0);
        run_op("mul_3_b", 2'b10, 4'd3, 4'hB, 1'b0, 1'b1);
        run_op("div_13_4", 2'b11, 4'd13, 4'd4, 1'b0, 1'b0);
        run_op("div_7_0", 2'b11, 4'd7, 4'd0, 1'b0, 1'b0);
        run_op("add_1_2", 2'b00, 4'd1, 4'd2, 1'b0, 1'b0);
        run_op("div_f_1", 2'b11, 4'hF, 4'd1, 1'b0, 1'b0);

        // Abort a multiply with reset; no Done may follow.
        @(negedge Clk);
        Select = 2'b10; A = 4'hF; B = 4'hF; Init = 1'b1;
        @(negedge Clk);
        Init = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        check("abort:sal", 32'(Sal), 32'd0);
        check("abort:busy", 32'(Busy), 32'd0);
        check("abort:done", 32'(Done), 32'd0);
        Rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(negedge Clk); seen |= Done; end
        check("abort:no_done", 32'(seen), 32'd0);
        run_op("add_6_7", 2'b00, 4'd6, 4'd7, 1'b0, 1'b0);

        @(negedge Clk);
        A8 = 8'hFF; B8 = 8'hFF; Init8 = 1'b1;
        @(negedge Clk);
        Init8 = 1'b0;
        lat = 0;
        while (Done8 !== 1'b1 && lat < 40) begin @(negedge Clk); lat++; end
        check("mul8:latency", 32'(lat), 32'd9);
        check("mul8:sal", 32'(Sal8), 32'hFE01);
        check("mul8:cout", 32'(Cout8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
